ks_datapath: RTL

- Datapath of the K&S processor; sits directly downstream of control_unit and executes its control signals.
- Holds the instruction register (IR), program counter (PC), 4x16-bit register file, ALU and flag register.
- Decodes the IR into k_and_s_pkg::decoded_instruction_type and returns that decode plus the registered ALU flags to control_unit.
- Drives the shared instruction/data RAM address, write data and read data paths.

---
 rtl/ks_datapath.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ks_datapath.sv
// K&S processor datapath: IR, PC, 4x16 register file, ALU and flag register.
// Decodes the IR for control_unit and drives the shared instruction/data RAM paths.
package k_and_s_pkg;
   typedef enum logic [3:0] {
      I_NOP    = 4'd0,
      I_BRANCH = 4'd1,
      I_BZERO  = 4'd2,
      I_BNEG   = 4'd3,
      I_BNZERO = 4'd4,
      I_BNNEG  = 4'd5,
      I_LOAD   = 4'd6,
      I_STORE  = 4'd7,
      I_MOVE   = 4'd8,
      I_ADD    = 4'd9,
      I_SUB    = 4'd10,
      I_AND    = 4'd11,
      I_OR     = 4'd12,
      I_HALT   = 4'd13
   } decoded_instruction_type;
endpackage

module ks_datapath #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   branch,
   input  logic                                   pc_enable,
   input  logic                                   ir_enable,
   input  logic                                   write_reg_enable,
   input  logic                                   addr_sel,
   input  logic                                   c_sel,
   input  logic [1:0]                             operation,
   input  logic                                   flags_reg_enable,
   output k_and_s_pkg::decoded_instruction_type   decoded_instruction,
   output logic                                   zero_op,
   output logic                                   neg_op,
   output logic                                   unsigned_overflow,
   output logic                                   signed_overflow,
   output logic [ADDR_WIDTH-1:0]                  ram_addr,
   output logic [DATA_WIDTH-1:0]                  data_out,
   input  logic [DATA_WIDTH-1:0]                  data_in
);
   import k_and_s_pkg::*;

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] ir;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] regs [4];

   logic [1:0]            a_idx;
   logic [1:0]            b_idx;
   logic [1:0]            dst_idx;
   logic [DATA_WIDTH-1:0] a_val;
   logic [DATA_WIDTH-1:0] b_val;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_carry;
   logic                  alu_ovf;
   logic [DATA_WIDTH-1:0] wb_data;

   // Opcode decode; unknown opcodes fall back to NOP
   always_comb begin
      case (ir[15:8])
         8'h00:   decoded_instruction = I_NOP;
         8'h01:   decoded_instruction = I_BRANCH;
         8'h02:   decoded_instruction = I_BZERO;
         8'h03:   decoded_instruction = I_BNEG;
         8'h0A:   decoded_instruction = I_BNZERO;
         8'h0B:   decoded_instruction = I_BNNEG;
         8'h81:   decoded_instruction = I_LOAD;
         8'h82:   decoded_instruction = I_STORE;
         8'h91:   decoded_instruction = I_MOVE;
         8'hA1:   decoded_instruction = I_ADD;
         8'hA2:   decoded_instruction = I_SUB;
         8'hA3:   decoded_instruction = I_AND;
         8'hA4:   decoded_instruction = I_OR;
         8'hFF:   decoded_instruction = I_HALT;
         default: decoded_instruction = I_NOP;
      endcase
   end

   // Register field selection; MOVE feeds the same source to both ALU ports
   always_comb begin
      a_idx   = ir[3:2];
      b_idx   = ir[1:0];
      dst_idx = ir[5:4];
      if (decoded_instruction == I_MOVE) begin
         a_idx   = ir[1:0];
         dst_idx = ir[3:2];
      end else if (decoded_instruction == I_LOAD) begin
         dst_idx = ir[6:5];
      end else begin
         dst_idx = ir[5:4];
      end
   end

   assign a_val    = regs[a_idx];
   assign b_val    = regs[b_idx];
   assign data_out = regs[ir[6:5]];
   assign ram_addr = addr_sel ? pc : ir[ADDR_WIDTH-1:0];

   // ALU with carry/borrow and two's-complement overflow
   always_comb begin
      sum        = {(DATA_WIDTH+1){1'b0}};
      alu_result = {DATA_WIDTH{1'b0}};
      alu_carry  = 1'b0;
      alu_ovf    = 1'b0;
      case (operation)
         2'b00: alu_result = a_val | b_val;
         2'b01: begin
            sum        = {1'b0, a_val} + {1'b0, b_val};
            alu_result = sum[MSB:0];
            alu_carry  = sum[DATA_WIDTH];
            alu_ovf    = (a_val[MSB] == b_val[MSB]) && (alu_result[MSB] != a_val[MSB]);
         end
         2'b10: begin
            // Borrow is the inverted carry of A + ~B + 1
            sum        = {1'b0, a_val} + {1'b0, ~b_val} + {{DATA_WIDTH{1'b0}}, 1'b1};
            alu_result = sum[MSB:0];
            alu_carry  = ~sum[DATA_WIDTH];
            alu_ovf    = (a_val[MSB] != b_val[MSB]) && (alu_result[MSB] != a_val[MSB]);
         end
         2'b11: alu_result = a_val & b_val;
         default: alu_result = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Write-back source select
   always_comb begin
      if (c_sel) begin
         wb_data = data_in;
      end else begin
         wb_data = alu_result;
      end
   end

   // State update; reset overrides every enable
   always_ff @(posedge clk) begin
      if (rst) begin
         ir                <= {DATA_WIDTH{1'b0}};
         pc                <= {ADDR_WIDTH{1'b0}};
         regs[0]           <= {DATA_WIDTH{1'b0}};
         regs[1]           <= {DATA_WIDTH{1'b0}};
         regs[2]           <= {DATA_WIDTH{1'b0}};
         regs[3]           <= {DATA_WIDTH{1'b0}};
         zero_op           <= 1'b0;
         neg_op            <= 1'b0;
         unsigned_overflow <= 1'b0;
         signed_overflow   <= 1'b0;
      end else begin
         if (ir_enable) begin
            ir <= data_in;
         end
         if (pc_enable) begin
            pc <= branch ? ir[ADDR_WIDTH-1:0] : pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         end
         if (write_reg_enable) begin
            regs[dst_idx] <= wb_data;
         end
         if (flags_reg_enable) begin
            zero_op           <= (alu_result == {DATA_WIDTH{1'b0}});
            neg_op            <= alu_result[MSB];
            unsigned_overflow <= alu_carry;
            signed_overflow   <= alu_ovf;
         end
      end
   end

endmodule
